bufcnt_ctrl: RTL and testbench
==============================

BUFCNT_CTRL -- requirements
Module: bufcnt_ctrl

Interface
REQ-001 The module SHALL have one clock, clk (input, 1): all state updates occur on its rising edge.
REQ-002 The module SHALL have reset rst (input, 1): asynchronous, active-high.
REQ-003 The module SHALL have SI (input, 1): serial line; idles high; frame = start bit 0, 8-bit length L MSB first, [parity bit], payload.
REQ-004 The module SHALL have co (input, 1): terminal-count flag from the downstream buffered counter stage.
REQ-005 The module SHALL have PI (output, 8): length L presented to the counter stage; the counter stage loads ~PI.
REQ-006 The module SHALL have ld (output, 1): one-cycle load strobe to the counter stage.
REQ-007 The module SHALL have en_cnt (output, 1): counter-stage count enable.
REQ-008 The module SHALL have en_tri (output, 1): counter-stage serial pass-through enable.
REQ-009 The module SHALL have busy (output, 1): high in every state except IDLE.
REQ-010 The module SHALL have done (output, 1): one-cycle pulse at the end of a frame.
REQ-011 The module SHALL have err (output, 1): one-cycle pulse on a parity failure; tied 0 when parity is not compiled in.

Function
REQ-012 The FSM SHALL have states IDLE, HDR, PAR, LOAD, XFER and DONE; PAR SHALL exist only under REQ-027.
REQ-013 In IDLE, a sampled SI=0 SHALL move the FSM to HDR on the next edge; SI=1 SHALL keep it in IDLE.
REQ-014 HDR SHALL shift SI into an 8-bit length register MSB first for exactly 8 cycles, using a 3-bit bit counter.
REQ-015 After the 8th HDR bit, the FSM SHALL go to PAR if compiled in, else to LOAD.
REQ-016 LOAD SHALL last exactly one cycle with ld=1, PI=L, en_cnt=0 and en_tri=0, then go to XFER.
REQ-017 PI SHALL hold L from LOAD until the FSM leaves DONE, and SHALL be 8'h00 otherwise.
REQ-018 XFER SHALL drive en_cnt=1 and en_tri=1 every cycle and SHALL leave for DONE on the first edge where co=1.
REQ-019 With a counter loaded with ~L, XFER SHALL last exactly L+1 cycles (L=0 -> 1 cycle; L=255 -> 256 cycles).
REQ-020 co SHALL be ignored in every state other than XFER.
REQ-021 DONE SHALL last one cycle with done=1 and all enables 0, then go to IDLE.
REQ-022 A new start bit SHALL be accepted at the earliest in the first IDLE cycle after DONE.
REQ-023 SI values in LOAD and DONE SHALL be ignored.
REQ-024 ld, en_cnt and en_tri SHALL never be high in the same cycle.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, with PI=0, ld=en_cnt=en_tri=busy=done=err=0 and the length and bit counters cleared.
REQ-026 Reset asserted mid-frame, including during XFER, SHALL abort the frame with no done or err pulse; the next frame SHALL require a fresh start bit.

Configuration
REQ-027 Macro BUFCNT_CTRL_PARITY_EN defined: PAR samples one bit, and frame validity is decided on odd parity over L plus this bit.
- Parity OK: go to LOAD.
- Parity bad: pulse err for one cycle, go to IDLE, never assert ld.
REQ-028 Macro BUFCNT_CTRL_PARITY_EN undefined: no PAR state and no parity bit in the frame; err is constant 0.

Verification
REQ-029 Scenario, nominal frame (macro off): SI=1 x3, then 0, then 8'h03 MSB first -> ld high 1 cycle with PI=8'h03; en_cnt/en_tri high 4 cycles until co; done pulses 1 cycle; busy drops.
REQ-030 Scenario, L=0: start bit, then 8'h00 -> XFER lasts 1 cycle (co immediate), then done.
REQ-031 Scenario, L=8'hFF: start bit, then 8'hFF -> 256 XFER cycles, done at the correct cycle, no counter wrap error.
REQ-032 Scenario, reset mid-frame: assert rst at XFER cycle 2 of L=5 -> all outputs 0 at once, no done; a following frame with L=2 completes normally.
REQ-033 Scenario, parity (macro on): start bit, L=8'h01, parity bit 0 -> LOAD/XFER as nominal; same frame with parity bit 1 -> err pulses 1 cycle, no ld, back to IDLE.
REQ-034 Scenario, back-to-back frames: a start bit present in the DONE cycle is ignored; a start bit in the following IDLE cycle begins the next frame.

Source files
------------

// File: rtl/bufcnt_ctrl_if.sv
// Serial-frame controller <-> buffered counter stage signal bundle.
// master: the controller; slave: the line source plus counter stage.
interface bufcnt_ctrl_if;
   logic       SI;
   logic       co;
   logic [7:0] PI;
   logic       ld;
   logic       en_cnt;
   logic       en_tri;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      input  SI, co,
      output PI, ld, en_cnt, en_tri, busy, done, err
   );

   modport slave (
      output SI, co,
      input  PI, ld, en_cnt, en_tri, busy, done, err
   );
endinterface

// File: rtl/bufcnt_ctrl.sv
// Frame parser driving a buffered down-counter: start bit, 8-bit length, payload pass-through.
// Optional odd-parity bit after the length when BUFCNT_CTRL_PARITY_EN is defined.
module bufcnt_ctrl (
   input  logic          clk,
   input  logic          rst,
   bufcnt_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      LOAD = 3'd2,
      XFER = 3'd3,
`ifdef BUFCNT_CTRL_PARITY_EN
      PAR  = 3'd5,
`endif
      DONE = 3'd4
   } state_t;

   state_t     state;
   state_t     nxt;
   logic [7:0] len;
   logic [2:0] bitcnt;
   logic [7:0] pi;
   logic       ld;
   logic       en_cnt;
   logic       en_tri;
   logic       done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         len    <= 8'h00;
         bitcnt <= 3'd0;
      end else begin
         state <= nxt;
         if (state == HDR) begin
            len    <= {len[6:0], bus.SI};
            bitcnt <= bitcnt + 3'd1;
         end else begin
            bitcnt <= 3'd0;
         end
      end
   end

`ifdef BUFCNT_CTRL_PARITY_EN
   logic par_ok;
   logic err_q;

   // Odd parity: L together with the parity bit must hold an odd number of ones.
   assign par_ok = ^{len, bus.SI};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state == PAR) && !par_ok;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   always_comb begin
      nxt    = state;
      pi     = 8'h00;
      ld     = 1'b0;
      en_cnt = 1'b0;
      en_tri = 1'b0;
      done   = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.SI) nxt = HDR;
         end
         HDR: begin
`ifdef BUFCNT_CTRL_PARITY_EN
            if (bitcnt == 3'd7) nxt = PAR;
`else
            if (bitcnt == 3'd7) nxt = LOAD;
`endif
         end
`ifdef BUFCNT_CTRL_PARITY_EN
         PAR: begin
            nxt = par_ok ? LOAD : IDLE;
         end
`endif
         LOAD: begin
            ld  = 1'b1;
            pi  = len;
            nxt = XFER;
         end
         XFER: begin
            en_cnt = 1'b1;
            en_tri = 1'b1;
            pi     = len;
            // co is only meaningful once the counter has been loaded and is counting.
            if (bus.co) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            pi   = len;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign bus.PI     = pi;
   assign bus.ld     = ld;
   assign bus.en_cnt = en_cnt;
   assign bus.en_tri = en_tri;
   assign bus.done   = done;
   assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_bufcnt_ctrl.sv
// Directed bench for bufcnt_ctrl with a behavioural model of the buffered counter stage.
module tb_bufcnt_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   bufcnt_ctrl_if bus();

   bufcnt_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Counter stage: loads ~PI, counts up while enabled, terminal count at 8'hFF.
   logic [7:0] cnt = 8'h00;
   always @(posedge clk) begin
      if (bus.ld) cnt <= ~bus.PI;
      else if (bus.en_cnt) cnt <= cnt + 8'd1;
   end
   assign bus.co = (cnt == 8'hFF);

   int         ld_tot = 0;
   int         xfer_tot = 0;
   int         done_tot = 0;
   int         err_tot = 0;
   int         ovl_tot = 0;
   logic [7:0] last_pi = 8'h00;

   always @(negedge clk) begin
      if (bus.ld === 1'b1) begin
         ld_tot  <= ld_tot + 1;
         last_pi <= bus.PI;
      end
      if (bus.en_cnt === 1'b1) xfer_tot <= xfer_tot + 1;
      if (bus.done === 1'b1) done_tot <= done_tot + 1;
      if (bus.err === 1'b1) err_tot <= err_tot + 1;
      if ((bus.ld & bus.en_cnt) === 1'b1 || (bus.ld & bus.en_tri) === 1'b1) ovl_tot <= ovl_tot + 1;
   end

   task automatic send_body(input logic [7:0] l, input logic bad);
      for (int i = 7; i >= 0; i--) begin
         bus.SI = l[i];
         @(posedge clk); #1;
      end
`ifdef BUFCNT_CTRL_PARITY_EN
      bus.SI = (~^l) ^ bad;
      @(posedge clk); #1;
`endif
      bus.SI = 1'b1;
   endtask

   task automatic send_hdr(input logic [7:0] l, input logic bad);
      bus.SI = 1'b0;
      @(posedge clk); #1;
      send_body(l, bad);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.SI = 1'b1;
      rst = 1'b1;
      #3;
      checks++; if (bus.ld !== 1'b0) begin failures++; $display("FAIL rst_ld got=%b exp=0", bus.ld); end
      checks++; if (bus.en_cnt !== 1'b0) begin failures++; $display("FAIL rst_en_cnt got=%b exp=0", bus.en_cnt); end
      checks++; if (bus.en_tri !== 1'b0) begin failures++; $display("FAIL rst_en_tri got=%b exp=0", bus.en_tri); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
      checks++; if (bus.PI !== 8'h00) begin failures++; $display("FAIL rst_pi got=%h exp=00", bus.PI); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      int ld0, x0, d0;
      bit ok;
      ld0 = ld_tot; x0 = xfer_tot; d0 = done_tot;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nom_idle_busy got=%b exp=0", bus.busy); end
      send_hdr(8'h03, 1'b0);
      checks++; if (bus.ld !== 1'b1) begin failures++; $display("FAIL nom_ld got=%b exp=1", bus.ld); end
      checks++; if (bus.PI !== 8'h03) begin failures++; $display("FAIL nom_load_pi got=%h exp=03", bus.PI); end
      checks++; if ({bus.en_cnt, bus.en_tri} !== 2'b00) begin failures++; $display("FAIL nom_load_en got=%b exp=00", {bus.en_cnt, bus.en_tri}); end
      @(posedge clk); #1;
      checks++; if ({bus.ld, bus.en_cnt, bus.en_tri} !== 3'b011) begin failures++; $display("FAIL nom_xfer_ctl got=%b exp=011", {bus.ld, bus.en_cnt, bus.en_tri}); end
      checks++; if (bus.PI !== 8'h03) begin failures++; $display("FAIL nom_xfer_pi got=%h exp=03", bus.PI); end
      wait_done(50, ok);
      checks++; if (!ok) begin failures++; $display("FAIL nom_done_timeout got=0 exp=1"); end
      checks++; if ({bus.en_cnt, bus.en_tri, bus.PI} !== {2'b00, 8'h03}) begin failures++; $display("FAIL nom_done_out got=%h exp=003", {bus.en_cnt, bus.en_tri, bus.PI}); end
      @(posedge clk); #1;
      checks++; if (xfer_tot - x0 !== 4) begin failures++; $display("FAIL nom_xfer_len got=%0d exp=4", xfer_tot - x0); end
      checks++; if (ld_tot - ld0 !== 1) begin failures++; $display("FAIL nom_ld_count got=%0d exp=1", ld_tot - ld0); end
      checks++; if (done_tot - d0 !== 1) begin failures++; $display("FAIL nom_done_count got=%0d exp=1", done_tot - d0); end
      checks++; if ({bus.busy, bus.done, bus.PI} !== 10'h000) begin failures++; $display("FAIL nom_after got=%h exp=000", {bus.busy, bus.done, bus.PI}); end
   endtask

   task automatic test_len(input logic [7:0] l, input int exp_x, input int budget);
      int x0;
      bit ok;
      x0 = xfer_tot;
      send_hdr(l, 1'b0);
      @(posedge clk); #1;
      wait_done(budget, ok);
      checks++; if (!ok) begin failures++; $display("FAIL len%h_timeout got=0 exp=1", l); end
      @(posedge clk); #1;
      checks++; if (xfer_tot - x0 !== exp_x) begin failures++; $display("FAIL len%h_xfer got=%0d exp=%0d", l, xfer_tot - x0, exp_x); end
      checks++; if (last_pi !== l) begin failures++; $display("FAIL len%h_pi got=%h exp=%h", l, last_pi, l); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL len%h_busy got=%b exp=0", l, bus.busy); end
   endtask

   task automatic test_reset_midframe();
      int d0, e0;
      d0 = done_tot; e0 = err_tot;
      send_hdr(8'h05, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (bus.en_cnt !== 1'b1) begin failures++; $display("FAIL mid_in_xfer got=%b exp=1", bus.en_cnt); end
      rst = 1'b1;
      #1;
      checks++; if ({bus.PI, bus.ld, bus.en_cnt, bus.en_tri, bus.busy, bus.done, bus.err} !== 14'h0) begin
         failures++; $display("FAIL mid_rst_out got=%h exp=0", {bus.PI, bus.ld, bus.en_cnt, bus.en_tri, bus.busy, bus.done, bus.err});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", bus.busy); end
      checks++; if (done_tot - d0 !== 0 || err_tot - e0 !== 0) begin failures++; $display("FAIL mid_no_pulse got=%0d/%0d exp=0/0", done_tot - d0, err_tot - e0); end
      test_len(8'h02, 3, 20);
   endtask

   task automatic test_back_to_back();
      int x0;
      bit ok;
      send_hdr(8'h01, 1'b0);
      @(posedge clk); #1;
      wait_done(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=0 exp=1"); end
      bus.SI = 1'b0;
      x0 = xfer_tot;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_si_ignored got=%b exp=0", bus.busy); end
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_start got=%b exp=1", bus.busy); end
      send_body(8'h05, 1'b0);
      checks++; if ({bus.ld, bus.PI} !== {1'b1, 8'h05}) begin failures++; $display("FAIL b2b_load got=%h exp=105", {bus.ld, bus.PI}); end
      @(posedge clk); #1;
      wait_done(30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_second_timeout got=0 exp=1"); end
      @(posedge clk); #1;
      checks++; if (xfer_tot - x0 !== 6) begin failures++; $display("FAIL b2b_xfer got=%0d exp=6", xfer_tot - x0); end
   endtask

`ifdef BUFCNT_CTRL_PARITY_EN
   task automatic test_parity();
      int ld0;
      ld0 = ld_tot;
      send_hdr(8'h01, 1'b1);
      checks++; if ({bus.err, bus.busy, bus.ld} !== 3'b100) begin failures++; $display("FAIL par_bad got=%b exp=100", {bus.err, bus.busy, bus.ld}); end
      @(posedge clk); #1;
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL par_err_width got=%b exp=0", bus.err); end
      checks++; if (ld_tot - ld0 !== 0) begin failures++; $display("FAIL par_no_ld got=%0d exp=0", ld_tot - ld0); end
      send_hdr(8'h01, 1'b0);
      checks++; if ({bus.ld, bus.err, bus.PI} !== {2'b10, 8'h01}) begin failures++; $display("FAIL par_good got=%h exp=201", {bus.ld, bus.err, bus.PI}); end
      repeat (4) begin @(posedge clk); #1; end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL par_good_end got=%b exp=0", bus.busy); end
   endtask
`endif

   initial begin
      bus.SI = 1'b1;
      test_reset();
      test_nominal();
      test_len(8'h00, 1, 20);
      test_len(8'hFF, 256, 300);
      test_reset_midframe();
      test_back_to_back();
`ifdef BUFCNT_CTRL_PARITY_EN
      test_parity();
`else
      checks++; if (err_tot !== 0) begin failures++; $display("FAIL err_tied got=%0d exp=0", err_tot); end
`endif
      checks++; if (ovl_tot !== 0) begin failures++; $display("FAIL ld_en_overlap got=%0d exp=0", ovl_tot); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
